nf10_upb_input_arbiter: RTL and testbench
=========================================

// Module: nf10_upb_input_arbiter
// PURPOSE
//  Packet-granular round-robin arbiter merging the 256-bit arbiter_m_axis streams of
//  C_NUM_PORTS nf10_upb_10g_input blocks into one stream toward the switch pipeline.
//  Grant is held for a whole packet (until the tlast handshake), so packets never
//  interleave. Re-arbitrates at each tlast with no bubble cycle; per-port enable mask.
// PARAMETERS
//  C_NUM_PORTS   4    number of requesting input ports (2..8)
//  C_DATA_WIDTH  256  tdata width; tkeep is C_DATA_WIDTH/8
// PORTS  (per-port buses flattened, port i in slice i)
//  axi_aclk                in   1        single clock
//  axi_reset               in   1        synchronous, active-high reset
//  s_axis_tdata            in   N*256    input data
//  s_axis_tkeep            in   N*32     input byte enables
//  s_axis_tuser_packet_length in N*14    packet length in bytes
//  s_axis_tuser_in_port    in   N*4      source port tag
//  s_axis_tuser_out_port   in   N*4      destination tag
//  s_axis_tvalid           in   N        per-port valid
//  s_axis_tlast            in   N        per-port last beat
//  s_axis_tready           out  N        per-port ready
//  m_axis_tdata            out  256      merged data
//  m_axis_tkeep            out  32       merged byte enables
//  m_axis_tuser_packet_length out 14     from granted port
//  m_axis_tuser_in_port    out  4        from granted port (passed through, not rewritten)
//  m_axis_tuser_out_port   out  4        from granted port
//  m_axis_tvalid           out  1        merged valid
//  m_axis_tready           in   1        downstream ready
//  m_axis_tlast            out  1        merged last
//  port_enable             in   N        1 = port may win arbitration
//  grant                   out  N        one-hot current grant, 0 when idle
//  pkt_count               out  N*32     packets forwarded per port, wraps at 2^32
// BEHAVIOUR
//  - State: IDLE (grant=0) / BUSY (grant one-hot, registered). rr_ptr = last winner.
//  - Eligible port i: s_axis_tvalid[i] & port_enable[i]. Winner = first eligible scanning
//    rr_ptr+1, rr_ptr+2, ... modulo N (rr_ptr itself is scanned last).
//  - IDLE: if any eligible, register grant=winner, rr_ptr=winner, go BUSY next cycle.
//    Latency valid->m_axis_tvalid = 1 cycle from IDLE.
//  - BUSY: m_axis_* = combinational mux of granted port (0 latency);
//    s_axis_tready[g] = m_axis_tready; all other s_axis_tready = 0.
//  - Handshake beat = m_axis_tvalid & m_axis_tready. On beat with tlast: pkt_count[g]++;
//    compute winner excluding nothing (rr order puts g last) from same-cycle valids;
//    if any eligible -> new grant next cycle (back-to-back, no bubble), else -> IDLE.
//  - port_enable sampled only at arbitration; clearing it mid-packet never aborts.
//  - Granted port deasserting tvalid mid-packet: grant held, m_axis_tvalid=0.
//  - Outputs when idle: m_axis_tvalid=0, m_axis_tlast=0, data/tuser fields 0.
//  - Reset: grant=0, state IDLE, rr_ptr=N-1 (port 0 wins first), pkt_count=0,
//    s_axis_tready=0, m_axis_tvalid=0. Reset mid-packet drops the rest of that
//    packet; the upstream FIFO's residual beats are then treated as a new packet.
//  - No packet-length check; upstream input block guarantees well-formed framing.
// TESTING
//  1 Port0 sends 3-beat pkt, m_tready=1 -> grant=0001 one cycle after valid, 3 beats out,
//    tlast on 3rd, pkt_count[0]=1.
//  2 All 4 ports hold 2-beat pkts -> output order 0,1,2,3,0 with no idle cycle between pkts.
//  3 m_tready pattern 1,0,0,1,1 during port2 pkt -> s_tready[2] mirrors it, m_tdata stable
//    while stalled, s_tready of other ports stays 0.
//  4 port_enable=1101, ports 1 and 3 valid -> only port3 granted; clear enable[3]
//    mid-packet -> packet completes, then grant=0.
//  5 axi_reset=1 on beat 2 of port1 pkt -> next cycle m_axis_tvalid=0, grant=0, counts=0;
//    after release with ports 1,0 valid -> port0 granted first.
//  6 Single-beat pkts (tlast on first beat) from ports 2,3 continuously -> grants alternate
//    2,3,2,3 every cycle, pkt_count increments each cycle; 32-bit count wraps to 0.

Source files
------------

// File: rtl/nf10_upb_input_arbiter.sv
// nf10_upb_input_arbiter
// Packet-granular round-robin merge of C_NUM_PORTS AXI4-Stream inputs into one
// output stream. A grant is held from the first beat of a packet until its tlast
// handshake. The next winner is chosen in that same cycle, so consecutive packets
// follow each other with no idle cycle in between.
module nf10_upb_input_arbiter #(
  parameter int C_NUM_PORTS  = 4,
  parameter int C_DATA_WIDTH = 256
) (
  input  logic                                   axi_aclk,
  input  logic                                   axi_reset,
  input  logic [C_NUM_PORTS*C_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [C_NUM_PORTS*(C_DATA_WIDTH/8)-1:0] s_axis_tkeep,
  input  logic [C_NUM_PORTS*14-1:0]               s_axis_tuser_packet_length,
  input  logic [C_NUM_PORTS*4-1:0]                s_axis_tuser_in_port,
  input  logic [C_NUM_PORTS*4-1:0]                s_axis_tuser_out_port,
  input  logic [C_NUM_PORTS-1:0]                  s_axis_tvalid,
  input  logic [C_NUM_PORTS-1:0]                  s_axis_tlast,
  output logic [C_NUM_PORTS-1:0]                  s_axis_tready,
  output logic [C_DATA_WIDTH-1:0]                 m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0]               m_axis_tkeep,
  output logic [13:0]                             m_axis_tuser_packet_length,
  output logic [3:0]                              m_axis_tuser_in_port,
  output logic [3:0]                              m_axis_tuser_out_port,
  output logic                                    m_axis_tvalid,
  input  logic                                    m_axis_tready,
  output logic                                    m_axis_tlast,
  input  logic [C_NUM_PORTS-1:0]                  port_enable,
  output logic [C_NUM_PORTS-1:0]                  grant,
  output logic [C_NUM_PORTS*32-1:0]               pkt_count
);

  localparam int KW = C_DATA_WIDTH / 8;
  localparam int PW = (C_NUM_PORTS > 1) ? $clog2(C_NUM_PORTS) : 1;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t                 state;
  state_t                 next_state;
  logic [C_NUM_PORTS-1:0] grant_q;
  logic [C_NUM_PORTS-1:0] next_grant;
  logic [PW-1:0]          rr_ptr;
  logic [PW-1:0]          next_rr;
  logic [C_NUM_PORTS-1:0] eligible;
  logic                   any_eligible;
  logic [PW-1:0]          winner;
  logic [C_NUM_PORTS-1:0] winner_onehot;
  logic                   last_beat;
  logic [31:0]            count [C_NUM_PORTS];

  assign eligible      = s_axis_tvalid & port_enable;
  assign winner_onehot = C_NUM_PORTS'(1) << winner;
  assign grant         = grant_q;
  assign s_axis_tready = grant_q & {C_NUM_PORTS{m_axis_tready}};
  assign m_axis_tvalid = |(grant_q & s_axis_tvalid);
  assign m_axis_tlast  = |(grant_q & s_axis_tlast);
  assign last_beat     = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  // Round-robin scan starting after the last winner, so the last winner is checked last
  always_comb begin
    logic [PW-1:0] idx;
    idx          = '0;
    any_eligible = 1'b0;
    winner       = rr_ptr;
    for (int k = 1; k <= C_NUM_PORTS; k++) begin
      idx = PW'((int'(rr_ptr) + k) % C_NUM_PORTS);
      if (!any_eligible && eligible[idx]) begin
        any_eligible = 1'b1;
        winner       = idx;
      end
    end
  end

  // Output mux: AND-OR of the one-hot grant, which yields all zeros while idle
  always_comb begin
    m_axis_tdata               = '0;
    m_axis_tkeep               = '0;
    m_axis_tuser_packet_length = '0;
    m_axis_tuser_in_port       = '0;
    m_axis_tuser_out_port      = '0;
    for (int i = 0; i < C_NUM_PORTS; i++) begin
      if (grant_q[i]) begin
        m_axis_tdata               = m_axis_tdata | s_axis_tdata[i*C_DATA_WIDTH +: C_DATA_WIDTH];
        m_axis_tkeep               = m_axis_tkeep | s_axis_tkeep[i*KW +: KW];
        m_axis_tuser_packet_length = m_axis_tuser_packet_length | s_axis_tuser_packet_length[i*14 +: 14];
        m_axis_tuser_in_port       = m_axis_tuser_in_port | s_axis_tuser_in_port[i*4 +: 4];
        m_axis_tuser_out_port      = m_axis_tuser_out_port | s_axis_tuser_out_port[i*4 +: 4];
      end
    end
  end

  // Next-state logic: arbitrate when idle, or on the tlast handshake of the held packet
  always_comb begin
    next_state = state;
    next_grant = grant_q;
    next_rr    = rr_ptr;
    case (state)
      IDLE: begin
        if (any_eligible) begin
          next_state = BUSY;
          next_grant = winner_onehot;
          next_rr    = winner;
        end
      end
      BUSY: begin
        if (last_beat) begin
          if (any_eligible) begin
            next_grant = winner_onehot;
            next_rr    = winner;
          end else begin
            next_state = IDLE;
            next_grant = '0;
          end
        end
      end
    endcase
  end

  // State, grant and round-robin pointer registers; pointer resets so port 0 wins first
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state   <= IDLE;
      grant_q <= '0;
      rr_ptr  <= PW'(C_NUM_PORTS - 1);
    end else begin
      state   <= next_state;
      grant_q <= next_grant;
      rr_ptr  <= next_rr;
    end
  end

  // Per-port forwarded-packet counters, bumped on each tlast handshake, wrapping naturally
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      for (int i = 0; i < C_NUM_PORTS; i++) count[i] <= '0;
    end else begin
      for (int i = 0; i < C_NUM_PORTS; i++) begin
        if (last_beat && grant_q[i]) count[i] <= count[i] + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < C_NUM_PORTS; g++) begin : g_count
    assign pkt_count[g*32 +: 32] = count[g];
  end

endmodule

// File: tb/tb_nf10_upb_input_arbiter.sv
// Testbench for nf10_upb_input_arbiter: randomized packet sources on every port,
// a packet-level reference model of the arbiter, and directed scenarios with
// literal expectations.
module tb_nf10_upb_input_arbiter;

  localparam int N  = 4;
  localparam int W  = 256;
  localparam int KW = W / 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N*W-1:0]  s_tdata;
  logic [N*KW-1:0] s_tkeep;
  logic [N*14-1:0] s_len;
  logic [N*4-1:0]  s_in;
  logic [N*4-1:0]  s_out;
  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tlast;
  logic [N-1:0]    s_tready;
  logic [W-1:0]    m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic [13:0]     m_len;
  logic [3:0]      m_in;
  logic [3:0]      m_out;
  logic            m_tvalid;
  logic            m_tready;
  logic            m_tlast;
  logic [N-1:0]    port_enable;
  logic [N-1:0]    grant;
  logic [N*32-1:0] pkt_count;

  always #5 clk = ~clk;

  nf10_upb_input_arbiter #(.C_NUM_PORTS(N), .C_DATA_WIDTH(W)) dut (
    .axi_aclk                   (clk),
    .axi_reset                  (reset),
    .s_axis_tdata               (s_tdata),
    .s_axis_tkeep               (s_tkeep),
    .s_axis_tuser_packet_length (s_len),
    .s_axis_tuser_in_port       (s_in),
    .s_axis_tuser_out_port      (s_out),
    .s_axis_tvalid              (s_tvalid),
    .s_axis_tlast               (s_tlast),
    .s_axis_tready              (s_tready),
    .m_axis_tdata               (m_tdata),
    .m_axis_tkeep               (m_tkeep),
    .m_axis_tuser_packet_length (m_len),
    .m_axis_tuser_in_port       (m_in),
    .m_axis_tuser_out_port      (m_out),
    .m_axis_tvalid              (m_tvalid),
    .m_axis_tready              (m_tready),
    .m_axis_tlast               (m_tlast),
    .port_enable                (port_enable),
    .grant                      (grant),
    .pkt_count                  (pkt_count)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // reference model: granted port index (-1 when idle), last winner, packet counts
  int          mg;
  int          mlast;
  logic [31:0] mcount [N];

  // packet sources
  int pkts_left [N];
  int beat_idx  [N];
  int cur_len   [N];
  int fixed_len;
  int gap_pct;
  int fixed_ready;
  int ready_pct;

  // values sampled at the falling edge
  logic [N-1:0]    snap_sval, snap_slast, snap_sready, snap_en, snap_grant;
  logic            snap_mready, snap_reset, snap_mvalid, snap_mlast;
  logic [W-1:0]    snap_mdata;
  logic [N*32-1:0] snap_count;

  int done_q[$];
  int beats;
  int first_beat_cyc;
  int last_beat_cyc;

  function automatic int pick(input logic [N-1:0] el, input int from);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (from + k) % N;
      if (el[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic cmp(input string nm, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, got, exp);
    end
  endtask

  task automatic checkOutput();
    logic [N-1:0]  eg, er;
    logic          ev, el;
    logic [W-1:0]  ed;
    logic [KW-1:0] ek;
    logic [21:0]   eu;
    eg = '0; er = '0; ev = 1'b0; el = 1'b0; ed = '0; ek = '0; eu = '0;
    if (mg >= 0) begin
      eg[mg] = 1'b1;
      er[mg] = m_tready;
      ev     = s_tvalid[mg];
      el     = s_tlast[mg];
      ed     = s_tdata[mg*W +: W];
      ek     = s_tkeep[mg*KW +: KW];
      eu     = {s_len[mg*14 +: 14], s_in[mg*4 +: 4], s_out[mg*4 +: 4]};
    end
    cmp("grant", grant, eg);
    cmp("s_tready", s_tready, er);
    cmp("m_tvalid", m_tvalid, ev);
    cmp("m_tlast", m_tlast, el);
    cmp("m_tdata", m_tdata, ed);
    cmp("m_tkeep", m_tkeep, ek);
    cmp("m_tuser", {m_len, m_in, m_out}, eu);
    for (int i = 0; i < N; i++) cmp($sformatf("pkt_count%0d", i), pkt_count[i*32 +: 32], mcount[i]);
  endtask

  task automatic model_update();
    logic [N-1:0] el;
    int w;
    el = snap_sval & snap_en;
    if (snap_reset) begin
      mg = -1;
      mlast = N - 1;
      for (int i = 0; i < N; i++) mcount[i] = '0;
    end else if (mg < 0) begin
      w = pick(el, mlast);
      if (w >= 0) begin mg = w; mlast = w; end
    end else if (snap_sval[mg] && snap_mready && snap_slast[mg]) begin
      mcount[mg] = mcount[mg] + 32'd1;
      w = pick(el, mlast);
      if (w >= 0) begin mg = w; mlast = w; end
      else mg = -1;
    end
  endtask

  task automatic applyStimulus();
    logic [N-1:0] acc;
    acc = snap_sval & snap_sready;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        if (snap_slast[i]) begin
          beat_idx[i] = 0;
          pkts_left[i] = pkts_left[i] - 1;
        end else begin
          beat_idx[i] = beat_idx[i] + 1;
        end
        s_tvalid[i] = 1'b0;
      end
      if (!s_tvalid[i]) begin
        if (pkts_left[i] > 0 && int'($urandom_range(99)) >= gap_pct) begin
          if (beat_idx[i] == 0) cur_len[i] = (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 4));
          s_tvalid[i]            = 1'b1;
          s_tlast[i]             = (beat_idx[i] == cur_len[i] - 1);
          s_tdata[i*W +: W]      = {8{$urandom}};
          s_tkeep[i*KW +: KW]    = $urandom;
          s_len[i*14 +: 14]      = 14'($urandom);
          s_in[i*4 +: 4]         = 4'($urandom);
          s_out[i*4 +: 4]        = 4'($urandom);
        end else begin
          s_tlast[i] = 1'b0;
        end
      end
    end
    if (fixed_ready >= 0) m_tready = fixed_ready[0];
    else m_tready = (int'($urandom_range(99)) < ready_pct);
  endtask

  task automatic step();
    @(negedge clk);
    snap_sval   = s_tvalid;
    snap_slast  = s_tlast;
    snap_sready = s_tready;
    snap_en     = port_enable;
    snap_mready = m_tready;
    snap_reset  = reset;
    snap_grant  = grant;
    snap_mvalid = m_tvalid;
    snap_mlast  = m_tlast;
    snap_mdata  = m_tdata;
    snap_count  = pkt_count;
    checkOutput();
    if (snap_mvalid && snap_mready && !snap_reset) begin
      beats++;
      if (first_beat_cyc < 0) first_beat_cyc = cyc;
      last_beat_cyc = cyc;
      if (snap_mlast) begin
        for (int i = 0; i < N; i++) if (snap_grant[i]) done_q.push_back(i);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    model_update();
    applyStimulus();
  endtask

  task automatic clear_sources();
    for (int i = 0; i < N; i++) begin
      pkts_left[i] = 0;
      beat_idx[i]  = 0;
      cur_len[i]   = 1;
    end
    s_tvalid = '0;
    s_tlast  = '0;
  endtask

  task automatic do_reset();
    clear_sources();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    done_q.delete();
    beats = 0;
    first_beat_cyc = -1;
    last_beat_cyc = -1;
  endtask

  task automatic set_common(input int len, input int gap, input int rdy);
    fixed_len   = len;
    gap_pct     = gap;
    fixed_ready = rdy;
    m_tready    = rdy[0];
    port_enable = '1;
  endtask

  task automatic wait_nonzero_grant(input string nm, input logic [N-1:0] exp);
    int n;
    step();
    n = 1;
    while (snap_grant == '0 && n < 50) begin
      step();
      n++;
    end
    cmp(nm, snap_grant, exp);
  endtask

  task automatic wait_done(input int cnt, input int budget);
    int n;
    n = 0;
    while (done_q.size() < cnt && n < budget) begin
      step();
      n++;
    end
    cmp("done_count", done_q.size(), cnt);
  endtask

  initial begin
    int pat [5];
    int exp_order [5];
    logic [W-1:0] prev_data;
    logic [N-1:0] e;
    pat       = '{1, 0, 0, 1, 1};
    exp_order = '{0, 1, 2, 3, 0};
    reset = 1'b1;
    s_tdata = '0; s_tkeep = '0; s_len = '0; s_in = '0; s_out = '0;
    s_tvalid = '0; s_tlast = '0; m_tready = 1'b0; port_enable = '1;
    fixed_len = 0; gap_pct = 0; fixed_ready = 0; ready_pct = 100;
    mg = -1; mlast = N - 1;
    for (int i = 0; i < N; i++) mcount[i] = '0;
    clear_sources();
    @(posedge clk);
    #1;
    do_reset();
    cmp("reset_grant", snap_grant, 4'b0000);
    cmp("reset_sready", snap_sready, 4'b0000);

    // single 3-beat packet from port 0
    set_common(3, 0, 1);
    pkts_left[0] = 1;
    step();
    step();
    cmp("t1_idle_grant", snap_grant, 4'b0000);
    cmp("t1_idle_mvalid", snap_mvalid, 1'b0);
    step();
    cmp("t1_grant", snap_grant, 4'b0001);
    cmp("t1_mvalid", snap_mvalid, 1'b1);
    step();
    step();
    cmp("t1_tlast", snap_mlast, 1'b1);
    step();
    cmp("t1_count0", snap_count[0 +: 32], 32'd1);
    cmp("t1_done", done_q.size(), 1);

    // all ports hold 2-beat packets: order 0,1,2,3,0 with no gaps
    do_reset();
    set_common(2, 0, 1);
    pkts_left[0] = 2; pkts_left[1] = 1; pkts_left[2] = 1; pkts_left[3] = 1;
    wait_done(5, 60);
    for (int k = 0; k < 5; k++) begin
      if (k < done_q.size()) cmp("t2_order", done_q[k], exp_order[k]);
    end
    cmp("t2_beats", beats, 10);
    cmp("t2_no_bubble", last_beat_cyc - first_beat_cyc, 9);

    // downstream stall pattern during a port 2 packet
    do_reset();
    set_common(3, 0, 0);
    pkts_left[2] = 1;
    wait_nonzero_grant("t3_grant", 4'b0100);
    prev_data = '0;
    for (int k = 0; k < 5; k++) begin
      fixed_ready = pat[k];
      m_tready = pat[k][0];
      step();
      cmp("t3_sready", snap_sready, (pat[k] != 0) ? 4'b0100 : 4'b0000);
      if (k > 0 && pat[k-1] == 0) cmp("t3_stable", snap_mdata, prev_data);
      prev_data = snap_mdata;
    end
    cmp("t3_done", done_q.size(), 1);

    // enable mask: only port 3 may win; disabling it mid-packet still completes it
    do_reset();
    set_common(3, 0, 1);
    port_enable = 4'b1101;
    pkts_left[1] = 1;
    pkts_left[3] = 1;
    wait_nonzero_grant("t4_grant", 4'b1000);
    port_enable = 4'b0101;
    wait_done(1, 20);
    step();
    cmp("t4_idle", snap_grant, 4'b0000);
    step();
    cmp("t4_still_idle", snap_grant, 4'b0000);

    // reset on the second beat of a port 1 packet
    do_reset();
    set_common(4, 0, 1);
    pkts_left[1] = 1;
    wait_nonzero_grant("t5_grant1", 4'b0010);
    reset = 1'b1;
    pkts_left[0] = 1;
    step();
    step();
    cmp("t5_rst_grant", snap_grant, 4'b0000);
    cmp("t5_rst_mvalid", snap_mvalid, 1'b0);
    cmp("t5_rst_count1", snap_count[32 +: 32], 32'd0);
    reset = 1'b0;
    step();
    step();
    cmp("t5_port0_first", snap_grant, 4'b0001);

    // back-to-back single-beat packets from ports 2 and 3
    do_reset();
    set_common(1, 0, 1);
    pkts_left[2] = 6;
    pkts_left[3] = 6;
    wait_nonzero_grant("t6_first", 4'b0100);
    for (int k = 1; k < 8; k++) begin
      step();
      e = (k % 2 == 1) ? 4'b1000 : 4'b0100;
      cmp("t6_alt", snap_grant, e);
    end
    step();
    cmp("t6_count2", snap_count[64 +: 32], 32'd4);
    cmp("t6_count3", snap_count[96 +: 32], 32'd4);

    // randomized traffic, enables, backpressure and occasional resets
    do_reset();
    set_common(0, 30, -1);
    ready_pct = 70;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (pkts_left[i] == 0 && $urandom_range(7) == 0) pkts_left[i] = int'($urandom_range(1, 3));
      end
      if (c % 50 == 0) port_enable = N'($urandom);
      reset = ($urandom_range(399) == 0);
      step();
    end
    reset = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
